// File: rtl/fc_sigmoid_stage_if.sv
// Stream bundle for fc_sigmoid_stage: z input handshake plus sigmoid output handshake.
// deriv_out exists only when SIG_DERIV_EN is defined.
interface fc_sigmoid_stage_if;
  logic [31:0] z_in;
  logic        z_valid;
  logic        z_ready;
  logic [9:0]  sig_out;
  logic [15:0] sig_index;
  logic        sig_valid;
  logic        sig_ready;
  logic        layer_done;
`ifdef SIG_DERIV_EN
  logic [9:0]  deriv_out;
`endif

  modport slave (
    input  z_in, z_valid, sig_ready,
    output z_ready, sig_out, sig_index, sig_valid, layer_done
`ifdef SIG_DERIV_EN
    , output deriv_out
`endif
  );

  modport master (
    output z_in, z_valid, sig_ready,
    input  z_ready, sig_out, sig_index, sig_valid, layer_done
`ifdef SIG_DERIV_EN
    , input deriv_out
`endif
  );
endinterface

// File: rtl/fc_sigmoid_stage.sv
// fc_sigmoid_stage: 3-stage pipelined PLAN sigmoid behind the FC MAC, with a per-layer index counter.
// Define SIG_DERIV_EN to add the registered sig*(1-sig) output deriv_out.
module fc_sigmoid_stage #(
  parameter int unsigned Z_FRAC      = 12,
  parameter int unsigned NUM_NEURONS = 40
) (
  input logic               clk,
  input logic               rst,
  fc_sigmoid_stage_if.slave bus
);
  localparam int unsigned YW = Z_FRAC + 1;

  localparam logic [30:0]   T_R1   = 31'(1 << Z_FRAC);
  localparam logic [30:0]   T_R2   = 31'((19 << Z_FRAC) >> 3);
  localparam logic [30:0]   T_R3   = 31'(5 << Z_FRAC);
  localparam logic [YW-1:0] OFS_R0 = YW'(1 << (Z_FRAC - 1));
  localparam logic [YW-1:0] OFS_R1 = YW'((5 << Z_FRAC) >> 3);
  localparam logic [YW-1:0] OFS_R2 = YW'((27 << Z_FRAC) >> 5);
  localparam logic [YW-1:0] Y_ONE  = YW'(1 << Z_FRAC);
  localparam logic [15:0]   LAST_IDX = 16'(NUM_NEURONS - 1);

  typedef enum logic [1:0] {REG_R0, REG_R1, REG_R2, REG_R3} region_e;

  logic          adv, out_xfer;
  logic [30:0]   abs_z;
  logic [10:0]   yq, fold;

  logic          v1_q, v1_d, sign1_q, sign1_d;
  logic [30:0]   a1_q, a1_d;
  region_e       reg1_q, reg1_d;

  logic          v2_q, v2_d, sign2_q, sign2_d;
  logic [YW-1:0] y2_q, y2_d, y_lin;

  logic          v3_q, v3_d, ld_q, ld_d;
  logic [9:0]    sig_q, sig_d;
  logic [15:0]   idx_q, idx_d;

  // Whole pipeline moves in lockstep; a stalled output freezes every stage.
  assign adv      = ~v3_q | bus.sig_ready;
  assign out_xfer = v3_q & bus.sig_ready;

  assign bus.z_ready    = adv;
  assign bus.sig_out    = sig_q;
  assign bus.sig_index  = idx_q;
  assign bus.sig_valid  = v3_q;
  assign bus.layer_done = ld_q;

  // Stage 1: magnitude (saturating for the most negative z) and region select
  always_comb begin
    v1_d    = v1_q;
    sign1_d = sign1_q;
    a1_d    = a1_q;
    reg1_d  = reg1_q;
    abs_z   = bus.z_in[30:0];
    if (bus.z_in[31]) begin
      abs_z = (bus.z_in == 32'h8000_0000) ? '1 : 31'(-bus.z_in);
    end
    if (adv) begin
      v1_d = bus.z_valid;
      if (bus.z_valid) begin
        sign1_d = bus.z_in[31];
        a1_d    = abs_z;
        if (abs_z < T_R1)      reg1_d = REG_R0;
        else if (abs_z < T_R2) reg1_d = REG_R1;
        else if (abs_z < T_R3) reg1_d = REG_R2;
        else                   reg1_d = REG_R3;
      end
    end
  end

  // Stage 2: linear segment; each region bounds a so the shifted term fits YW bits
  always_comb begin
    unique case (reg1_q)
      REG_R0:  y_lin = YW'(a1_q >> 2) + OFS_R0;
      REG_R1:  y_lin = YW'(a1_q >> 3) + OFS_R1;
      REG_R2:  y_lin = YW'(a1_q >> 5) + OFS_R2;
      default: y_lin = Y_ONE;
    endcase
    v2_d    = v2_q;
    sign2_d = sign2_q;
    y2_d    = y2_q;
    if (adv) begin
      v2_d = v1_q;
      if (v1_q) begin
        sign2_d = sign1_q;
        y2_d    = y_lin;
      end
    end
  end

  // Stage 3: scale to 10 fractional bits, fold negative inputs, clamp 1.0 to 1023
  always_comb begin
    yq    = 11'(y2_q >> (Z_FRAC - 10));
    fold  = sign2_q ? (11'd1024 - yq) : yq;
    v3_d  = v3_q;
    sig_d = sig_q;
    if (adv) begin
      v3_d = v2_q;
      if (v2_q) sig_d = fold[10] ? 10'h3FF : fold[9:0];
    end
  end

  // Index counts output transfers only; layer_done is the registered wrap event
  always_comb begin
    idx_d = idx_q;
    ld_d  = 1'b0;
    if (out_xfer) begin
      if (idx_q == LAST_IDX) begin
        idx_d = '0;
        ld_d  = 1'b1;
      end else begin
        idx_d = idx_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1_q    <= 1'b0;
      sign1_q <= 1'b0;
      a1_q    <= '0;
      reg1_q  <= REG_R0;
      v2_q    <= 1'b0;
      sign2_q <= 1'b0;
      y2_q    <= '0;
      v3_q    <= 1'b0;
      sig_q   <= '0;
      idx_q   <= '0;
      ld_q    <= 1'b0;
    end else begin
      v1_q    <= v1_d;
      sign1_q <= sign1_d;
      a1_q    <= a1_d;
      reg1_q  <= reg1_d;
      v2_q    <= v2_d;
      sign2_q <= sign2_d;
      y2_q    <= y2_d;
      v3_q    <= v3_d;
      sig_q   <= sig_d;
      idx_q   <= idx_d;
      ld_q    <= ld_d;
    end
  end

`ifdef SIG_DERIV_EN
  logic [21:0] prod;
  logic [9:0]  deriv_q, deriv_d;

  assign bus.deriv_out = deriv_q;

  // Uses the unclamped fold (0..1024) so saturated outputs give exactly 0
  always_comb begin
    prod    = {11'd0, fold} * {11'd0, 11'd1024 - fold};
    deriv_d = deriv_q;
    if (adv && v2_q) deriv_d = 10'(prod >> 10);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) deriv_q <= '0;
    else      deriv_q <= deriv_d;
  end
`endif

endmodule

// File: tb/tb_fc_sigmoid_stage.sv
// Scoreboard bench for fc_sigmoid_stage: expectations queued on input acceptance, checked on output transfer.
module tb_fc_sigmoid_stage;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fc_sigmoid_stage_if bus();
  fc_sigmoid_stage #(.Z_FRAC(12), .NUM_NEURONS(40)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [9:0]  sig;
    logic [9:0]  der;
    logic [15:0] idx;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_chk = 0;
  int   n_fail = 0;
  int   n_acc = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Independent reference: fixed Q19.12 thresholds/offsets, returns folded value 0..1024
  function automatic int model_fold(input logic [31:0] z);
    longint a, y, q;
    a = longint'($signed(z));
    if (a < 0) a = -a;
    if (a > 64'sd2147483647) a = 64'sd2147483647;
    if (a < 4096)       y = a / 4 + 2048;
    else if (a < 9728)  y = a / 8 + 2560;
    else if (a < 20480) y = a / 32 + 3456;
    else                y = 4096;
    q = y / 4;
    if (z[31]) q = 1024 - q;
    return int'(q);
  endfunction

  function automatic logic [9:0] sat_sig(input int f);
    return (f > 1023) ? 10'd1023 : 10'(f);
  endfunction

  function automatic logic [31:0] rand_z();
    int v;
    v = int'($urandom_range(0, 60000)) - 30000;
    return 32'(v);
  endfunction

  task automatic push_exp(input logic [9:0] s, input logic [9:0] d);
    exp_t t;
    t.sig = s;
    t.der = d;
    t.idx = 16'(n_acc % 40);
    t.cyc = cyc;
    sb.push_back(t);
    n_acc++;
  endtask

  task automatic push_z(input logic [31:0] z);
    int f;
    f = model_fold(z);
    push_exp(sat_sig(f), 10'((f * (1024 - f)) / 1024));
  endtask

  task automatic set_in(input logic v, input logic [31:0] z, input logic r);
    bus.z_valid   = v;
    bus.z_in      = z;
    bus.sig_ready = r;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    set_in(1'b0, '0, 1'b1);
    repeat (2) @(negedge clk);
    n_chk++;
    if (bus.sig_valid !== 1'b0 || bus.sig_index !== 16'd0 || bus.sig_out !== 10'd0 || bus.layer_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got valid=%0b idx=%0d sig=%0d done=%0b, required 0/0/0/0",
               bus.sig_valid, bus.sig_index, bus.sig_out, bus.layer_done);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_wrap();
    logic ld_exp = 1'b0;
    int   pulses = 0;
    int   sent = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      set_in(sent < 41, rand_z(), 1'b1);
      n_chk++;
      if (bus.layer_done !== ld_exp) begin
        n_fail++;
        $display("FAIL wrap_layer_done: cycle %0d got %0b, required %0b", i, bus.layer_done, ld_exp);
      end
      if (bus.layer_done === 1'b1) pulses++;
      ld_exp = bus.sig_valid && bus.sig_ready && (bus.sig_index == 16'd39);
      if (bus.sig_valid && bus.sig_ready) begin
        n_chk++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL wrap_extra: got sig=%0d idx=%0d, required no output", bus.sig_out, bus.sig_index);
        end else begin
          e = sb.pop_front();
          if (bus.sig_out !== e.sig || bus.sig_index !== e.idx) begin
            n_fail++;
            $display("FAIL wrap_data: got sig=%0d idx=%0d, required sig=%0d idx=%0d",
                     bus.sig_out, bus.sig_index, e.sig, e.idx);
          end
        end
      end
      if (bus.z_valid && bus.z_ready) begin
        push_z(bus.z_in);
        sent++;
      end
    end
    n_chk++;
    if (pulses != 1 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL wrap_summary: got pulses=%0d pending=%0d, required 1/0", pulses, sb.size());
    end
  endtask

  task automatic test_sweep();
    logic [31:0] zt [8] = '{32'h0, 32'd4096, 32'hFFFF_F000, 32'd8192,
                            32'd12288, 32'd20480, 32'hFFFF_B000, 32'h8000_0000};
    logic [9:0]  st [8] = '{10'd512, 10'd768, 10'd256, 10'd896, 10'd960, 10'd1023, 10'd0, 10'd0};
    int k = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      set_in(i < 8, (i < 8) ? zt[i] : 32'h0, 1'b1);
      if (bus.sig_valid && bus.sig_ready) begin
        n_chk++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL sweep_extra: got sig=%0d, required no output", bus.sig_out);
        end else begin
          e = sb.pop_front();
          if (bus.sig_out !== e.sig || bus.sig_index !== e.idx) begin
            n_fail++;
            $display("FAIL sweep_data: got sig=%0d idx=%0d, required sig=%0d idx=%0d",
                     bus.sig_out, bus.sig_index, e.sig, e.idx);
          end
          n_chk++;
          if (cyc - e.cyc != 3) begin
            n_fail++;
            $display("FAIL sweep_latency: got %0d cycles, required 3", cyc - e.cyc);
          end
        end
      end
      if (bus.z_valid && bus.z_ready) begin
        push_exp(st[k], 10'd0);
        k++;
      end
    end
    n_chk++;
    if (sb.size() != 0 || k != 8) begin
      n_fail++;
      $display("FAIL sweep_drain: got pending=%0d accepted=%0d, required 0/8", sb.size(), k);
    end
  endtask

  task automatic test_backpressure();
    int         sent = 0, got = 0, stall = 4;
    logic       rdy;
    logic [9:0] held;
    logic [15:0] held_i;
    for (int i = 0; i < 60 && got < 10; i++) begin
      @(negedge clk);
      rdy = !(bus.sig_valid && got == 3 && stall > 0);
      set_in(sent < 10, rand_z(), rdy);
      if (!rdy) begin
        stall--;
        n_chk++;
        if (bus.z_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL bp_z_ready: got %0b while stalled, required 0", bus.z_ready);
        end
        if (stall == 3) begin
          held   = bus.sig_out;
          held_i = bus.sig_index;
        end else begin
          n_chk++;
          if (bus.sig_out !== held || bus.sig_index !== held_i || bus.sig_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_hold: got sig=%0d idx=%0d valid=%0b, required sig=%0d idx=%0d valid=1",
                     bus.sig_out, bus.sig_index, bus.sig_valid, held, held_i);
          end
        end
      end
      if (bus.sig_valid && bus.sig_ready) begin
        n_chk++;
        got++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL bp_extra: got sig=%0d idx=%0d, required no output", bus.sig_out, bus.sig_index);
        end else begin
          e = sb.pop_front();
          if (bus.sig_out !== e.sig || bus.sig_index !== e.idx) begin
            n_fail++;
            $display("FAIL bp_data: got sig=%0d idx=%0d, required sig=%0d idx=%0d",
                     bus.sig_out, bus.sig_index, e.sig, e.idx);
          end
        end
      end
      if (bus.z_valid && bus.z_ready) begin
        push_z(bus.z_in);
        sent++;
      end
    end
    n_chk++;
    if (got != 10 || sb.size() != 0 || stall != 0) begin
      n_fail++;
      $display("FAIL bp_summary: got outputs=%0d pending=%0d stall_left=%0d, required 10/0/0",
               got, sb.size(), stall);
    end
  endtask

  task automatic test_bubbles();
    int acc = 0, got = 0;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      set_in((i < 12) && (i % 2 == 0), rand_z(), 1'b1);
      if (bus.sig_valid && bus.sig_ready) begin
        n_chk++;
        got++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL bubble_extra: got sig=%0d idx=%0d, required no output", bus.sig_out, bus.sig_index);
        end else begin
          e = sb.pop_front();
          if (bus.sig_out !== e.sig || bus.sig_index !== e.idx) begin
            n_fail++;
            $display("FAIL bubble_data: got sig=%0d idx=%0d, required sig=%0d idx=%0d",
                     bus.sig_out, bus.sig_index, e.sig, e.idx);
          end
        end
      end
      if (bus.z_valid && bus.z_ready) begin
        push_z(bus.z_in);
        acc++;
      end
    end
    n_chk++;
    if (got != 6 || acc != 6 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL bubble_count: got outputs=%0d accepted=%0d, required 6/6", got, acc);
    end
  endtask

`ifdef SIG_DERIV_EN
  task automatic test_deriv();
    logic [31:0] zt [3] = '{32'h0, 32'd4096, 32'd20480};
    logic [9:0]  st [3] = '{10'd512, 10'd768, 10'd1023};
    logic [9:0]  dt [3] = '{10'd256, 10'd192, 10'd0};
    int k = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      set_in(i < 3, (i < 3) ? zt[i] : 32'h0, 1'b1);
      if (bus.sig_valid && bus.sig_ready) begin
        n_chk++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL deriv_extra: got deriv=%0d, required no output", bus.deriv_out);
        end else begin
          e = sb.pop_front();
          if (bus.deriv_out !== e.der || bus.sig_out !== e.sig) begin
            n_fail++;
            $display("FAIL deriv_data: got deriv=%0d sig=%0d, required deriv=%0d sig=%0d",
                     bus.deriv_out, bus.sig_out, e.der, e.sig);
          end
        end
      end
      if (bus.z_valid && bus.z_ready) begin
        push_exp(st[k], dt[k]);
        k++;
      end
    end
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL deriv_drain: got pending=%0d, required 0", sb.size());
    end
  endtask
`endif

  task automatic test_reset_midstream();
    int seen = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      set_in(1'b1, rand_z(), 1'b1);
    end
    @(negedge clk);
    set_in(1'b0, '0, 1'b1);
    rst = 1'b0;
    #1;
    n_chk++;
    if (bus.sig_valid !== 1'b0 || bus.sig_index !== 16'd0 || bus.sig_out !== 10'd0) begin
      n_fail++;
      $display("FAIL midreset_async: got valid=%0b idx=%0d sig=%0d, required 0/0/0",
               bus.sig_valid, bus.sig_index, bus.sig_out);
    end
    sb.delete();
    n_acc = 0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.sig_valid === 1'b1) seen++;
    end
    n_chk++;
    if (seen != 0 || bus.sig_index !== 16'd0) begin
      n_fail++;
      $display("FAIL midreset_flush: got stale outputs=%0d idx=%0d, required 0/0", seen, bus.sig_index);
    end
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      set_in(i == 0, 32'd4096, 1'b1);
      if (bus.sig_valid && bus.sig_ready) begin
        n_chk++;
        seen++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL midreset_extra: got sig=%0d, required no output", bus.sig_out);
        end else begin
          e = sb.pop_front();
          if (bus.sig_out !== 10'd768 || bus.sig_index !== 16'd0 || cyc - e.cyc != 3) begin
            n_fail++;
            $display("FAIL midreset_first: got sig=%0d idx=%0d lat=%0d, required 768/0/3",
                     bus.sig_out, bus.sig_index, cyc - e.cyc);
          end
        end
      end
      if (bus.z_valid && bus.z_ready) push_z(bus.z_in);
    end
    n_chk++;
    if (seen != 1) begin
      n_fail++;
      $display("FAIL midreset_count: got %0d outputs, required 1", seen);
    end
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_sweep();
    test_backpressure();
    test_bubbles();
`ifdef SIG_DERIV_EN
    test_deriv();
`endif
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fc_sigmoid_stage.md
Name: fc_sigmoid_stage

Overview:
- Activation stage directly downstream of the fully-connected MAC.
- Consumes one signed 32-bit pre-activation z per neuron and produces a 10-bit unsigned sigmoid output using a 3-stage pipelined piecewise-linear (PLAN) approximation.
- Uses valid/ready handshakes on both sides and a per-layer neuron counter. Flags the end of each layer pass for the weight-update stage.

Parameters:
- Z_FRAC, 12, number of fractional bits in z (signed Q19.12).
- NUM_NEURONS, 40, neurons per layer pass; sets the index wrap and the done point.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-low reset
- z_in  in  32  signed pre-activation, Q(31-Z_FRAC).Z_FRAC
- z_valid  in  1  z_in is valid
- z_ready  out  1  stage accepts z_in this cycle
- sig_out  out  10  sigmoid result, unsigned Q0.10; 1023 ≈ 1.0
- sig_index  out  16  neuron index of sig_out, 0..NUM_NEURONS-1
- sig_valid  out  1  sig_out/sig_index are valid
- sig_ready  in  1  downstream accepts sig_out
- layer_done  out  1  one-cycle pulse on acceptance of index NUM_NEURONS-1
- deriv_out  out  10  sig*(1-sig), Q0.10; present only with SIG_DERIV_EN

Behaviour:
- Reset: asserting rst low immediately clears all stage valids, sig_valid, sig_out, sig_index, layer_done and deriv_out to 0. This applies mid-operation too; in-flight data is discarded. Release is synchronous to clk.
- Handshake:
  - An input transfers when z_valid && z_ready.
  - An output transfers when sig_valid && sig_ready.
  - Global advance: adv = ~sig_valid | sig_ready. All stages shift only when adv=1.
  - z_ready = adv, which is combinational from sig_ready.
- Latency: 3 cycles from input acceptance to sig_valid when there are no stalls. Throughput is 1 per cycle.
- sig_out and sig_index hold stable while sig_valid && ~sig_ready.
- Stage 1 (abs and region):
  - Register sign = z[31] and a = |z|.
  - a saturates to 2^31-1 for z = -2^31.
  - Region thresholds, in Z_FRAC units:
    - R0: a < 1.0
    - R1: 1.0 ≤ a < 2.375
    - R2: 2.375 ≤ a < 5.0
    - R3: a ≥ 5.0
- Stage 2 (linear segment), computed in Q.Z_FRAC, result unsigned:
  - R0: y = a>>2 + 0.5
  - R1: y = a>>3 + 0.625
  - R2: y = a>>5 + 0.84375
  - R3: y = 1.0
- Stage 3 (fold and scale):
  - yq = y >> (Z_FRAC-10), truncating, 11 bits.
  - If sign = 1: yq = 1024 - yq.
  - sig_out = min(yq, 1023).
- Counter:
  - sig_index increments on each output transfer.
  - When index NUM_NEURONS-1 transfers: layer_done pulses for that next cycle and the index wraps to 0.
  - The counter never advances without an output transfer.
- Simultaneous events: an input acceptance and an output transfer in the same cycle are both honoured, so the pipeline stays full.
- A bubble (z_valid=0 while adv=1) propagates as an invalid stage. Bubbles do not count.

Optional Feature:
- Macro: SIG_DERIV_EN.
- Defined:
  - Stage 3 also registers deriv_out = (yq_sat × (1024 - yq_sat)) >> 10, using the pre-saturation-clamped yq limited to 0..1024.
  - Range is 0..256.
  - Timing and handshake are identical to sig_out.
- Undefined: the deriv_out port and its multiplier are absent. All other behaviour is unchanged.

Test Plan:
- Reset: hold rst low for 3 cycles mid-stream with 2 samples in flight -> sig_valid=0 and index 0 after release; the next input appears as index 0 three cycles after acceptance.
- Value sweep with sig_ready=1 and z = 0, 4096, -4096, 8192, 12288, 20480, -20480, -2^31 -> sig_out = 512, 768, 256, 896, 960, 1023, 0, 0. Each output follows 3 cycles after its input.
- Backpressure: stream 10 inputs and drop sig_ready for 4 cycles at output 3 -> z_ready=0 while stalled, sig_out held constant, no loss or duplication, indices 0..9 in order.
- Layer wrap: 41 consecutive inputs -> layer_done pulses once, in the cycle after index 39 transfers; the 41st output carries sig_index=0.
- Bubbles: z_valid toggling 1,0,1,0 -> only valid outputs are emitted, and indices are contiguous.
- SIG_DERIV_EN: z = 0, 4096, 20480 -> deriv_out = 256, 192, 0. Without the macro, the build has no deriv_out port.
